// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - arbiter state type, header marker and round-robin pick helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, HDR, GRANT, DRAIN} arb_state_e;

  localparam logic [3:0] HDR_MARKER = 4'hA;

  // First set bit of req strictly after 'last', searching upward with wrap over num_ch entries.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last,
                                         input int num_ch);
    logic [3:0] idx;
    rr_next = last;
    for (int k = 16; k >= 1; k--) begin
      if (k <= num_ch) begin
        idx = 4'((int'(last) + k) % num_ch);
        if (req[idx]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin request picker
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  pick,
  output logic              any_req
);

  assign pick    = IDX_W'(rr_next(16'(req), 4'(last), NUM_CH));
  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter feeding uart_tx; UART_ARB_HDR_EN prefixes each grant with a header byte
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(NUM_CH)-1:0]    grant_id,
  output logic                         busy
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;

  logic                  out_ready, any_req, g_valid, g_last, g_accept;
  logic [IDX_W-1:0]      pick;
  logic [DATA_WIDTH-1:0] g_data;

  uart_rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req     (s_axis_tvalid),
    .last    (grant_q),
    .pick    (pick),
    .any_req (any_req)
  );

  assign out_ready = !tvalid_q || m_axis_tready;
  assign g_valid   = s_axis_tvalid[grant_q];
  assign g_last    = s_axis_tlast[grant_q];
  assign g_data    = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign g_accept  = (state_q == GRANT) && g_valid && out_ready;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == GRANT) s_axis_tready[grant_q] = out_ready;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q && !m_axis_tready;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
`ifdef UART_ARB_HDR_EN
          state_d    = HDR;
`else
          state_d    = GRANT;
`endif
        end
      end
      HDR: begin
        if (out_ready) begin
          tdata_d  = DATA_WIDTH'({HDR_MARKER, 4'(grant_q)});
          tvalid_d = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // An accepted beat always wins over an expiring idle timer.
        if (g_accept) begin
          tdata_d    = g_data;
          tvalid_d   = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          idle_cnt_d = '0;
          if (g_last || beat_cnt_d == BEAT_LAST) state_d = DRAIN;
        end else if (!g_valid) begin
          if (idle_cnt_q == IDLE_LAST) state_d = DRAIN;
          else idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= IDX_W'(NUM_CH - 1);
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE) || tvalid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (header bytes expected when UART_ARB_HDR_EN is defined)
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IT  = 16;
`ifdef UART_ARB_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*DW-1:0] s_axis_tdata;
  logic [NCH-1:0]    s_axis_tvalid;
  logic [NCH-1:0]    s_axis_tlast;
  logic [NCH-1:0]    s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [1:0]        grant_id;
  logic              busy;

  uart_tx_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [8:0]  txq [NCH][$];
  logic [11:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input int ch, input logic [7:0] d, input logic last);
    txq[ch].push_back({last, d});
  endtask

  task automatic exp_byte(input int ch, input logic [7:0] d);
    exp_q.push_back({4'(ch), d});
  endtask

  task automatic exp_hdr(input int ch);
    if (HDR_EN) exp_q.push_back({4'(ch), HDR_MARKER, 4'(ch)});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL %s_done: %0d bytes still expected, busy=%0b", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(m_axis_tvalid), 32'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) txq[c].delete();
    exp_q.delete();
    #1;
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'(NCH - 1));
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
  endtask

  // Per-channel producers: present queue head, pop after a handshake.
  initial begin
    logic [NCH-1:0] fire;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid & s_axis_tready;
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) begin
        if (fire[c] && txq[c].size() > 0) void'(txq[c].pop_front());
        if (txq[c].size() > 0) begin
          s_axis_tvalid[c]          = 1'b1;
          s_axis_tdata[c*DW +: DW]  = txq[c][0][7:0];
          s_axis_tlast[c]           = txq[c][0][8];
        end else begin
          s_axis_tvalid[c] = 1'b0;
          s_axis_tlast[c]  = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard pops on each sink handshake, plus hold-stability under backpressure.
  initial begin
    logic        stalled_prev;
    logic [7:0]  held;
    logic [11:0] e;
    stalled_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stalled_prev) begin
          check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
          check("hold_tdata", 32'(m_axis_tdata), 32'(held));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL extra_beat: got data %0h grant %0d, expected no output", m_axis_tdata, grant_id);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(m_axis_tdata), 32'(e[7:0]));
            check("beat_grant", 32'(grant_id), 32'(e[11:8]));
          end
        end
      end
      stalled_prev = rst_n && m_axis_tvalid && !m_axis_tready;
      held = m_axis_tdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    apply_reset();

    // Single 3-byte packet from ch0; busy drops one edge after the last byte leaves.
    send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b1);
    exp_hdr(0); exp_byte(0, 8'h11); exp_byte(0, 8'h22); exp_byte(0, 8'h33);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
      check("t1_bytes_out", 32'(exp_q.size()), 32'd0);
      check("t1_busy_last", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("t1_busy_fall", 32'(busy), 32'd0);
    end
    check("t1_grant", 32'(grant_id), 32'd0);

    // ch1 and ch3 together with grant_id=0: ch1 packet whole, then ch3.
    send(1, 8'hA1, 1'b0); send(1, 8'hA2, 1'b1);
    send(3, 8'hB1, 1'b0); send(3, 8'hB2, 1'b1);
    exp_hdr(1); exp_byte(1, 8'hA1); exp_byte(1, 8'hA2);
    exp_hdr(3); exp_byte(3, 8'hB1); exp_byte(3, 8'hB2);
    wait_drain("t2");

    // All channels, two 1-byte packets each: order 0,1,2,3,0,1,2,3.
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) send(c, 8'(8'h40 + 16*r + c), 1'b1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) begin
        exp_hdr(c);
        exp_byte(c, 8'(8'h40 + 16*r + c));
      end
    wait_drain("t3");

    // ch2 6 bytes, no tlast: forced release after 4, regrant for the last 2.
    for (int i = 0; i < 6; i++) send(2, 8'(8'hC0 + i), 1'b0);
    exp_hdr(2);
    for (int i = 0; i < 4; i++) exp_byte(2, 8'(8'hC0 + i));
    exp_hdr(2);
    for (int i = 4; i < 6; i++) exp_byte(2, 8'(8'hC0 + i));
    wait_drain("t4");
    check("t4_grant", 32'(grant_id), 32'd2);

    // ch0 stalls mid-packet, ch1 waiting; sink backpressured for 50 cycles.
    send(0, 8'h5A, 1'b0);
    send(1, 8'h61, 1'b0); send(1, 8'h62, 1'b1);
    exp_hdr(0); exp_byte(0, 8'h5A);
    exp_hdr(1); exp_byte(1, 8'h61); exp_byte(1, 8'h62);
    wait_out_valid("t5_first_out");
    m_axis_tready = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_drain("t5");
    check("t5_grant", 32'(grant_id), 32'd1);

    // ch3 single byte (header A3 in front when enabled).
    send(3, 8'h55, 1'b1);
    exp_hdr(3); exp_byte(3, 8'h55);
    wait_drain("t6");

    // Reset while a byte is held in the output stage.
    m_axis_tready = 1'b0;
    send(1, 8'h71, 1'b0); send(1, 8'h72, 1'b0); send(1, 8'h73, 1'b1);
    wait_out_valid("t7_loaded");
    apply_reset();
    repeat (4) @(posedge clk);
    #1;
    check("t7_post_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t7_post_busy", 32'(busy), 32'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
